// File: rtl/rcv_pkg.sv
// Shared types and constants for the receive FIFO controller.
package rcv_pkg;

  localparam int WORDS_PER_BLK = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {IDLE, FILL, STALL, FLUSH} rcv_state_t;

  // NONSEQ and SEQ carry data; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    act = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/rcv_timeout_cnt.sv
// Idle-cycle counter used to detect an abandoned partial block.
module rcv_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Clear wins over count; the count saturates once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rcv_fifo_ctrl.sv
// Receive FIFO sequencer: AHB-lite writes -> word enqueues, bus stall when
// no block slot is free, block hand-off to the consumer, and timeout flush
// of abandoned partial blocks.
module rcv_fifo_ctrl
  import rcv_pkg::*;
#(
  parameter int BLK_DEPTH = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HWRITE,
  input  logic       HREADY,
  output logic       HREADYOUT,
  input  logic       fifo_full,
  input  logic       framing_error,
  output logic       rcv_enq_word,
  output logic       fix_error,
  output logic       rcv_deq,
  output logic       blk_valid,
  input  logic       blk_ready,
  output logic [1:0] blk_count,
  output logic       err_irq,
  input  logic       err_clr
);

  localparam logic [1:0] DEPTH_C   = 2'(BLK_DEPTH);
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLK - 1);

  rcv_state_t state_q, state_d;
  logic       pend_wr_q, pend_wr_d;
  logic [1:0] word_idx_q, word_idx_d;
  logic [1:0] blk_count_q, blk_count_d;
  logic       err_irq_q, err_irq_d;

  logic accept;
  logic stall;
  logic in_flush;
  logic enq;
  logic deq;
  logic blk_done;
  logic expired;
  logic tmo_clear;
  logic tmo_en;

  assign accept   = HSEL && HWRITE && HREADY && htrans_active(HTRANS);
  assign in_flush = (state_q == FLUSH);
  // A new block can only start when a slot is free; mid-block words always fit.
  assign stall    = pend_wr_q && (word_idx_q == 2'd0) && (blk_count_q == DEPTH_C);
  assign enq      = pend_wr_q && !stall && !in_flush;
  assign blk_done = enq && (word_idx_q == LAST_WORD);
  assign deq      = (blk_count_q != 2'd0) && blk_ready && !in_flush;

  assign HREADYOUT    = !stall && !in_flush;
  assign rcv_enq_word = enq;
  assign rcv_deq      = deq;
  assign fix_error    = in_flush;
  assign blk_valid    = (blk_count_q != 2'd0);
  assign blk_count    = blk_count_q;
  assign err_irq      = err_irq_q;

  // Timer runs only while a partial block sits idle.
  assign tmo_en    = (state_q == FILL);
  assign tmo_clear = enq || (state_q != FILL);

  rcv_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (expired)
  );

  // Datapath next-state: pending write, word index, block count, error flag.
  always_comb begin
    pend_wr_d   = pend_wr_q;
    word_idx_d  = word_idx_q;
    blk_count_d = blk_count_q;
    err_irq_d   = err_irq_q;

    // A write held by wait states stays pending until it is taken.
    if (HREADYOUT) begin
      pend_wr_d = accept;
    end

    if (in_flush) begin
      word_idx_d = 2'd0;
    end else if (enq) begin
      word_idx_d = word_idx_q + 2'd1;
    end

    case ({blk_done, deq})
      2'b10:   blk_count_d = blk_count_q + 2'd1;
      2'b01:   blk_count_d = blk_count_q - 2'd1;
      default: blk_count_d = blk_count_q;
    endcase

    if (in_flush) begin
      err_irq_d = 1'b1;
    end else if (err_clr) begin
      err_irq_d = 1'b0;
    end
  end

  // Write-side FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = STALL;
        end else if (enq) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (stall) begin
          state_d = STALL;
        end else if (blk_done) begin
          state_d = IDLE;
        end else if (!enq && expired) begin
          state_d = FLUSH;
        end
      end
      STALL: begin
        // The released write is word 0 of a new block, so it leaves a partial block.
        if (!stall) begin
          state_d = enq ? FILL : IDLE;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_wr_q   <= 1'b0;
      word_idx_q  <= 2'd0;
      blk_count_q <= 2'd0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_wr_q   <= pend_wr_d;
      word_idx_q  <= word_idx_d;
      blk_count_q <= blk_count_d;
      err_irq_q   <= err_irq_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(blk_done && !deq && (blk_count_q == DEPTH_C)));

  a_framing: assert property (@(posedge clk) disable iff (rst)
    !in_flush |-> (framing_error == (word_idx_q != 2'd0)));

  a_full: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (blk_count_q == DEPTH_C));

endmodule
